pred_bram_reader: RTL and testbench

//  Read-side counterpart of the classifier's prediction BRAM writer. On start it reads
//  num_preds 2-bit predictions from the prediction BRAM, beginning at start_addr.
//  It packs them LSB-first into 32-bit words and streams them on AXI4-Stream with full

---
 rtl/pred_bram_reader.sv | 168 ++++++++++++++++
 tb/tb_pred_bram_reader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pred_bram_reader.sv
// Streams num_preds 2-bit predictions from the prediction BRAM as LSB-first packed AXI4-Stream words.
// Define PRED_HIST_EN to add per-class saturating prediction counters on hist_counts.
module pred_bram_reader #(
  parameter int unsigned PRED_BITS      = 2,
  parameter int unsigned BRAM_ADDR_BITS = 14,
  parameter int unsigned OUT_WIDTH      = 32,
  parameter int unsigned RD_LATENCY     = 1
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      start,
  input  logic [BRAM_ADDR_BITS-1:0] start_addr,
  input  logic [BRAM_ADDR_BITS:0]   num_preds,
  output logic                      busy,
  output logic                      done,
  output logic [BRAM_ADDR_BITS-1:0] bram_ADDR,
  output logic                      bram_EN,
  input  logic [PRED_BITS-1:0]      bram_DATA,
  output logic [OUT_WIDTH-1:0]      out_TDATA,
  output logic                      out_TVALID,
  input  logic                      out_TREADY,
  output logic                      out_TLAST
`ifdef PRED_HIST_EN
  ,
  output logic [4*(BRAM_ADDR_BITS+1)-1:0] hist_counts
`endif
);

  localparam int unsigned PACK   = OUT_WIDTH / PRED_BITS;
  localparam int unsigned CNT_W  = BRAM_ADDR_BITS + 1;
  localparam int unsigned LANE_W = $clog2(PACK) + 1;
  localparam int unsigned SUM_W  = CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      num_q, issued_q, returned_q;
  logic [RD_LATENCY-1:0] en_pipe_q;
  logic [RD_LATENCY:0]   en_sh_c;
  logic [OUT_WIDTH-1:0]  pack_q, pack_nxt_c;
  logic [LANE_W-1:0]     pack_cnt_q;
  logic                  pack_full_q, pack_last_q;
  logic                  accept_c, hs_c, out_free_c, rd_vld_c, ret_last_c;
  logic                  room_c, issue_c, word_done_c;

  // Issue/return bookkeeping; a read is only issued when its data is guaranteed a slot.
  always_comb begin
    accept_c    = (state_q == S_IDLE) && start;
    hs_c        = out_TVALID && out_TREADY;
    out_free_c  = !out_TVALID || out_TREADY;
    en_sh_c     = {en_pipe_q, bram_EN};
    rd_vld_c    = en_pipe_q[RD_LATENCY-1];
    ret_last_c  = rd_vld_c && ((returned_q + CNT_W'(1)) == num_q);
    room_c      = (SUM_W'(pack_cnt_q) + SUM_W'(issued_q - returned_q)) < SUM_W'(PACK);
    issue_c     = (state_q == S_READ) && (issued_q < num_q) && (room_c || out_free_c);
    pack_nxt_c  = pack_q | (OUT_WIDTH'(bram_DATA) << (PRED_BITS * 32'(pack_cnt_q)));
    word_done_c = rd_vld_c && ((pack_cnt_q == LANE_W'(PACK - 1)) || ret_last_c);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (num_preds == '0) ? S_DONE : S_READ;
      S_READ:  if (issue_c && ((issued_q + CNT_W'(1)) == num_q)) state_d = S_DRAIN;
      S_DRAIN: if (hs_c && out_TLAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Read issue, pack assembly and the AXIS output register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      bram_ADDR   <= '0;
      bram_EN     <= 1'b0;
      out_TDATA   <= '0;
      out_TVALID  <= 1'b0;
      out_TLAST   <= 1'b0;
      num_q       <= '0;
      issued_q    <= '0;
      returned_q  <= '0;
      en_pipe_q   <= '0;
      pack_q      <= '0;
      pack_cnt_q  <= '0;
      pack_full_q <= 1'b0;
      pack_last_q <= 1'b0;
    end else begin
      busy      <= (state_d != S_IDLE);
      done      <= (state_d == S_DONE);
      en_pipe_q <= en_sh_c[RD_LATENCY-1:0];
      bram_EN   <= 1'b0;
      if (accept_c) begin
        num_q       <= num_preds;
        returned_q  <= '0;
        bram_ADDR   <= start_addr;
        bram_EN     <= (num_preds != '0);
        issued_q    <= (num_preds != '0) ? CNT_W'(1) : '0;
        pack_q      <= '0;
        pack_cnt_q  <= '0;
        pack_full_q <= 1'b0;
        pack_last_q <= 1'b0;
      end else begin
        if (issue_c) begin
          bram_EN   <= 1'b1;
          bram_ADDR <= bram_ADDR + BRAM_ADDR_BITS'(1);
          issued_q  <= issued_q + CNT_W'(1);
        end
        if (rd_vld_c) returned_q <= returned_q + CNT_W'(1);
        if (hs_c) begin
          out_TVALID <= 1'b0;
          out_TLAST  <= 1'b0;
        end
        if (pack_full_q) begin
          if (out_free_c) begin
            out_TDATA   <= pack_q;
            out_TLAST   <= pack_last_q;
            out_TVALID  <= 1'b1;
            pack_q      <= '0;
            pack_cnt_q  <= '0;
            pack_full_q <= 1'b0;
            pack_last_q <= 1'b0;
          end
        end else if (word_done_c) begin
          if (out_free_c) begin
            out_TDATA  <= pack_nxt_c;
            out_TLAST  <= ret_last_c;
            out_TVALID <= 1'b1;
            pack_q     <= '0;
            pack_cnt_q <= '0;
          end else begin
            // Output still occupied: park the finished word until the beat ahead drains.
            pack_q      <= pack_nxt_c;
            pack_cnt_q  <= pack_cnt_q + LANE_W'(1);
            pack_full_q <= 1'b1;
            pack_last_q <= ret_last_c;
          end
        end else if (rd_vld_c) begin
          pack_q     <= pack_nxt_c;
          pack_cnt_q <= pack_cnt_q + LANE_W'(1);
        end
      end
    end
  end

`ifdef PRED_HIST_EN
  // Per-class counters, cleared on each accepted start.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      hist_counts <= '0;
    end else if (accept_c) begin
      hist_counts <= '0;
    end else if (rd_vld_c) begin
      for (int c = 0; c < 4; c++) begin
        if ((bram_DATA == PRED_BITS'(c)) && (hist_counts[c*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
          hist_counts[c*CNT_W +: CNT_W] <= hist_counts[c*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pred_bram_reader.sv
// Randomised bench for pred_bram_reader against a queue-based packing model of the BRAM contents.
`timescale 1ns/1ps
module tb_pred_bram_reader;
  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;
  localparam int PACK  = 16;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   num_preds = '0;
  logic          busy, done, bram_EN, out_TVALID, out_TLAST;
  logic          out_TREADY = 1'b1;
  logic [AW-1:0] bram_ADDR;
  logic [1:0]    bram_DATA = '0;
  logic [31:0]   out_TDATA;
`ifdef PRED_HIST_EN
  logic [4*(AW+1)-1:0] hist_counts;
`endif

  pred_bram_reader dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .start_addr(start_addr),
    .num_preds(num_preds), .busy(busy), .done(done), .bram_ADDR(bram_ADDR),
    .bram_EN(bram_EN), .bram_DATA(bram_DATA), .out_TDATA(out_TDATA),
    .out_TVALID(out_TVALID), .out_TREADY(out_TREADY), .out_TLAST(out_TLAST)
`ifdef PRED_HIST_EN
    , .hist_counts(hist_counts)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  // BRAM with one cycle of read latency
  logic [1:0] mem [DEPTH];
  always @(posedge ap_clk) if (bram_EN) bram_DATA <= mem[bram_ADDR];

  int checks = 0, failures = 0, cyc = 0;
  bit active = 0, done_seen = 0, prev_stall = 0;
  int start_cyc = 0, exp_n = 0, exp_addr = 0, en_cnt = 0;
  int first_valid_rel = -1, last_hs_rel = -1, done_rel = -1, rel = 0, rdy_mode = 0;
  logic [31:0] exp_q[$], got_q[$], w, prev_data;
  logic prev_last;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected beats: predictions laid LSB-first, 16 per word, last word zero-filled.
  task automatic build_model(input int addr, input int n);
    logic [31:0] word;
    exp_q.delete();
    for (int b = 0; b < (n + PACK - 1) / PACK; b++) begin
      word = '0;
      for (int j = 0; j < PACK; j++)
        if (b * PACK + j < n) word |= 32'(mem[(addr + b * PACK + j) % DEPTH]) << (2 * j);
      exp_q.push_back(word);
    end
  endtask

  initial forever begin
    @(posedge ap_clk); #1;
    case (rdy_mode)
      0:       out_TREADY = 1'b1;
      1:       out_TREADY = 1'($urandom_range(0, 1));
      default: out_TREADY = 1'b0;
    endcase
  end

  // Per-cycle compare against the model.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      chk({busy, done, bram_EN, out_TVALID, out_TLAST} == 5'b0 && bram_ADDR == '0 && out_TDATA == '0,
          "reset_outputs", {busy, done, bram_EN, out_TVALID, out_TLAST}, 0);
      prev_stall = 0;
    end else begin
      rel = cyc - start_cyc;
      chk(busy == (active && rel >= 1), "busy", busy, active && rel >= 1);
      if (bram_EN) begin
        chk(active && en_cnt < exp_n && int'(bram_ADDR) == (exp_addr + en_cnt) % DEPTH,
            "bram_addr", bram_ADDR, (exp_addr + en_cnt) % DEPTH);
        en_cnt++;
      end
      if (prev_stall)
        chk(out_TVALID && out_TDATA == prev_data && out_TLAST == prev_last, "axis_hold", out_TDATA, prev_data);
      if (out_TVALID) begin
        if (first_valid_rel < 0) first_valid_rel = rel;
        if (out_TREADY) begin
          if (exp_q.size() == 0) chk(1'b0, "extra_beat", out_TDATA, 0);
          else begin
            w = exp_q.pop_front();
            chk(out_TDATA == w, "tdata", out_TDATA, w);
            chk(out_TLAST == (exp_q.size() == 0), "tlast", out_TLAST, exp_q.size() == 0);
            got_q.push_back(out_TDATA);
            if (out_TLAST) last_hs_rel = rel;
          end
        end
      end
      if (done) begin
        if (exp_n > 0) chk(active && rel == last_hs_rel + 1, "done_timing", rel, last_hs_rel + 1);
        else           chk(active && rel >= 1 && rel <= 2, "done_zero_timing", rel, 2);
        done_rel = rel;
        done_seen = 1;
        active = 0;
      end
      prev_stall = out_TVALID && !out_TREADY;
      prev_data  = out_TDATA;
      prev_last  = out_TLAST;
    end
  end

  task automatic run_start(input int addr, input int n);
    @(posedge ap_clk); #1;
    build_model(addr, n);
    exp_addr = addr; exp_n = n; en_cnt = 0;
    first_valid_rel = -1; last_hs_rel = -1; done_rel = -1; done_seen = 0;
    got_q.delete();
    start_cyc = cyc; active = 1;
    start = 1'b1; start_addr = AW'(addr); num_preds = (AW+1)'(n);
    @(posedge ap_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (!done_seen && t < budget) begin @(posedge ap_clk); t++; end
    chk(done_seen, "done_timeout", t, budget);
    @(negedge ap_clk);
    chk(exp_q.size() == 0, "beats_missing", exp_q.size(), 0);
    chk(en_cnt == exp_n, "read_count", en_cnt, exp_n);
  endtask

  task automatic fill_mod4();
    for (int k = 0; k < DEPTH; k++) mem[k] = 2'(k % 4);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < DEPTH; k++) mem[k] = 2'($urandom_range(0, 3));
  endtask

  int snap;
  initial begin
    fill_mod4();
    #1 ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    repeat (2) @(posedge ap_clk);

    // One full beat with k%4 data
    run_start(0, 16); wait_done(100);
    chk(got_q.size() == 1 && got_q[0] == 32'hE4E4E4E4, "t1_word", got_q.size() > 0 ? got_q[0] : 0, 32'hE4E4E4E4);
    chk(first_valid_rel == 18, "t1_first_valid", first_valid_rel, 18);
    chk(done_rel == 19, "t1_done_cycle", done_rel, 19);
`ifdef PRED_HIST_EN
    for (int c = 0; c < 4; c++) chk(hist_counts[c*(AW+1) +: (AW+1)] == 4, "t1_hist", hist_counts[c*(AW+1) +: (AW+1)], 4);
`endif

    // Partial last beat
    run_start(0, 20); wait_done(200);
    chk(got_q.size() == 2 && got_q[0] == 32'hE4E4E4E4 && got_q[1] == 32'h000000E4, "t2_words",
        got_q.size() > 1 ? got_q[1] : 0, 32'h000000E4);

    // Address wrap
    run_start(16'h3FF8, 16); wait_done(100);
    chk(got_q.size() == 1 && got_q[0] == 32'hE4E4E4E4, "t3_wrap_word", got_q.size() > 0 ? got_q[0] : 0, 32'hE4E4E4E4);

    // Long backpressure with an ignored start mid-run
    fill_rand();
    run_start(16'h0100, 64);
    repeat (8) @(posedge ap_clk);
    rdy_mode = 2;
    #1 start = 1'b1; start_addr = AW'(16'h2000); num_preds = (AW+1)'(5);
    @(posedge ap_clk); #1 start = 1'b0;
    repeat (30) @(posedge ap_clk);
    snap = en_cnt;
    repeat (19) @(posedge ap_clk);
    chk(en_cnt == snap, "t4_read_stall", en_cnt, snap);
    rdy_mode = 0;
    wait_done(400);
    chk(got_q.size() == 4, "t4_beats", got_q.size(), 4);

    // Zero-length run, second start while busy
    run_start(0, 0);
    start = 1'b1; start_addr = '0; num_preds = (AW+1)'(16);
    @(posedge ap_clk); #1 start = 1'b0;
    wait_done(10);
    repeat (20) @(posedge ap_clk);
    chk(got_q.size() == 0 && en_cnt == 0, "t5_no_activity", got_q.size() + en_cnt, 0);

    // Reset in the middle of a read phase
    run_start(16'h0040, 64);
    repeat (5) @(posedge ap_clk);
    #1 ap_rst_n = 1'b0; active = 0; exp_q.delete();
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    repeat (3) @(posedge ap_clk);
    fill_mod4();
    run_start(0, 16); wait_done(100);
    chk(got_q.size() == 1 && got_q[0] == 32'hE4E4E4E4, "t6_word_after_reset", got_q.size() > 0 ? got_q[0] : 0, 32'hE4E4E4E4);
    chk(first_valid_rel == 18, "t6_first_valid", first_valid_rel, 18);

    // Random runs with random backpressure
    fill_rand();
    rdy_mode = 1;
    for (int r = 0; r < 10; r++) begin
      int a, n;
      a = (r % 3 == 0) ? $urandom_range(DEPTH - 40, DEPTH - 1) : $urandom_range(0, DEPTH - 1);
      n = $urandom_range(1, 100);
      run_start(a, n);
      wait_done(n * 10 + 200);
      chk(got_q.size() == (n + PACK - 1) / PACK, "rand_beats", got_q.size(), (n + PACK - 1) / PACK);
      repeat ($urandom_range(0, 4)) @(posedge ap_clk);
    end
    rdy_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
